// File: rtl/mult_s4_accum_if.sv
// ---------------------------------------------------------------------------
// mult_s4_accum_if
//
// This interface bundles the product input stream, the group-sum output stream
// and the abort strobe of the mult_s4_accum block.
//
// Signals
//   abort       synchronous group discard, driven towards the accumulator
//   prod        8-bit signed product from the 4-bit signed multiplier
//   prod_valid  prod is valid this cycle
//   prod_ready  accumulator accepts prod this cycle
//   sum         ACC_W-bit signed group sum
//   sum_ovf     at least one step of the group overflowed (or clamped)
//   sum_valid   sum / sum_ovf are valid
//   sum_ready   downstream accepts sum
//
// Modports
//   slave   the accumulator side (mult_s4_accum)
//   master  the side that feeds products and takes sums (upstream/downstream)
// ---------------------------------------------------------------------------
interface mult_s4_accum_if #(
   parameter int ACC_W = 8
);
   logic             abort;
   logic [7:0]       prod;
   logic             prod_valid;
   logic             prod_ready;
   logic [ACC_W-1:0] sum;
   logic             sum_ovf;
   logic             sum_valid;
   logic             sum_ready;

   modport slave (
      input  abort,
      input  prod,
      input  prod_valid,
      output prod_ready,
      output sum,
      output sum_ovf,
      output sum_valid,
      input  sum_ready
   );

   modport master (
      output abort,
      output prod,
      output prod_valid,
      input  prod_ready,
      input  sum,
      input  sum_ovf,
      input  sum_valid,
      output sum_ready
   );
endinterface

// File: rtl/mult_s4_accum.sv
// ---------------------------------------------------------------------------
// mult_s4_accum
//
// This block is a signed group accumulator that sits downstream of the 4-bit
// signed multiplier. It takes one 8-bit two's-complement product per
// handshake. After COUNT products it presents the group sum together with a
// sticky overflow flag on a valid/ready output.
//
// Ports
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   mult_s4_accum_if.slave (abort, prod/prod_valid/prod_ready,
//         sum/sum_ovf/sum_valid/sum_ready)
//
// Parameters
//   ACC_W  accumulator / result width, >= 8
//   COUNT  products per group, >= 1
//
// Build option
//   MULT_S4_ACCUM_SAT_EN  when defined, each step saturates to the signed
//                         ACC_W range instead of wrapping. The clamped value
//                         feeds the next step, and a clamp sets sum_ovf.
//                         When undefined, the sum wraps modulo 2^ACC_W and no
//                         clamp logic exists.
//
// FSM
//   IDLE   waiting for the first product of a group
//   ACCUM  collecting products 2..COUNT (gaps allowed, no timeout)
//   DONE   holding the result until sum_ready. The block refuses products
//          in this state, which gives the mandatory one-cycle bubble.
// ---------------------------------------------------------------------------
module mult_s4_accum #(
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input  logic          clk,
   input  logic          rst,
   mult_s4_accum_if.slave bus
);

   localparam int CNT_W = $clog2(COUNT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

`ifdef MULT_S4_ACCUM_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic signed [ACC_W-1:0] acc_reg, acc_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic                    ovf_reg, ovf_next;

   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] step_base;
   logic signed [ACC_W-1:0] step_raw;
   logic signed [ACC_W-1:0] step_res;
   logic                    step_ovf;
   logic                    prod_ready_int;
   logic                    accept;

   // -----------------------------------------------------------------------
   // Datapath for one accumulation step
   // -----------------------------------------------------------------------
   assign prod_ext = ACC_W'($signed(bus.prod));

   // The first product of a group starts from zero. Using zero as the base
   // lets the IDLE and ACCUM states share one adder, and it means step_ovf
   // can never fire on the first product.
   assign step_base = (state_reg == IDLE) ? '0 : acc_reg;
   assign step_raw  = step_base + prod_ext;

   // Signed overflow can only occur when both operands have the same sign
   // and the result's sign differs from theirs.
   assign step_ovf = (step_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (step_raw[ACC_W-1]  != step_base[ACC_W-1]);

`ifdef MULT_S4_ACCUM_SAT_EN
   // On overflow, clamp toward the sign of the operands. Both operands have
   // the same sign when step_ovf is set, so step_base's sign chooses the rail.
   assign step_res = step_ovf ? (step_base[ACC_W-1] ? ACC_MIN : ACC_MAX)
                              : step_raw;
`else
   assign step_res = step_raw;
`endif

   // -----------------------------------------------------------------------
   // Input handshake
   // -----------------------------------------------------------------------
   // Ready is held low during reset, during an abort cycle and while a
   // result is pending. As a result, the upstream holds the product instead
   // of losing it.
   assign prod_ready_int = !rst && !bus.abort && (state_reg != DONE);
   assign accept         = bus.prod_valid && prod_ready_int;

   // -----------------------------------------------------------------------
   // FSM: next state and next datapath values
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      ovf_next   = ovf_reg;

      if (bus.abort) begin
         // This discards the whole group, including a DONE result that is
         // being handed off in the same cycle.
         state_next = IDLE;
         acc_next   = '0;
         cnt_next   = '0;
         ovf_next   = 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (accept) begin
                  acc_next   = step_res;
                  ovf_next   = 1'b0;
                  cnt_next   = ONE_CNT;
                  state_next = (COUNT == 1) ? DONE : ACCUM;
               end
            end

            ACCUM: begin
               if (accept) begin
                  acc_next = step_res;
                  cnt_next = cnt_reg + ONE_CNT;
                  ovf_next = ovf_reg | step_ovf;
                  if (cnt_reg == LAST_CNT) begin
                     state_next = DONE;
                  end
               end
            end

            DONE: begin
               // acc and ovf remain intact. They are cleared or overwritten
               // by the first product of the next group.
               if (bus.sum_ready) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            end

            default: begin
               state_next = IDLE;
               acc_next   = '0;
               cnt_next   = '0;
               ovf_next   = 1'b0;
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         ovf_reg   <= ovf_next;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   // sum and sum_ovf are read straight from the accumulator. They cannot
   // change while in DONE, so they stay stable until the hand-off. The
   // asynchronous reset clears all of them immediately.
   assign bus.prod_ready = prod_ready_int;
   assign bus.sum        = acc_reg;
   assign bus.sum_ovf    = ovf_reg;
   assign bus.sum_valid  = (state_reg == DONE);

endmodule
